// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues program-memory reads from the current PC and
// queues fetched words in a 2-entry prefetch buffer for the decoder.
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 14,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               flush,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t     state, next_state;
  logic [1:0] count, count_next;
  entry_t     fifo_mem [2];
  logic       issue, push, pop, wr_idx, head_avail;
  entry_t     head_next;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: if (!flush && count != 2'd2) begin
        next_state = WAIT;
        issue      = 1'b1;
      end
      WAIT: if (mem_ack) begin
        next_state = IDLE;
        push       = !flush;
      end else if (flush) begin
        next_state = DROP;
      end
      DROP: if (mem_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign pop = ir_valid && ir_ready && !flush;

  // Entries shift toward slot 0 on a pop, so a push lands after the survivors.
  always_comb begin
    wr_idx     = pop ? (count == 2'd2) : (count != 2'd0);
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  // The ir register follows the head as it stands before this edge's push,
  // which gives one edge of latency from push to ir_valid.
  always_comb begin
    head_next  = fifo_mem[0];
    head_avail = (count != 2'd0);
    if (pop) begin
      head_next  = fifo_mem[1];
      head_avail = (count == 2'd2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 2'd0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      pc_advance <= 1'b0;
      ir         <= NOP_WORD;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= count_next;
      mem_req    <= (next_state != IDLE);
      pc_advance <= issue;
      if (issue) mem_addr <= pc;
      if (flush || !head_avail) begin
        ir       <= NOP_WORD;
        ir_pc    <= '0;
        ir_valid <= 1'b0;
      end else begin
        ir       <= head_next.instr;
        ir_pc    <= head_next.addr;
        ir_valid <= 1'b1;
      end
    end
  end

  // NOTE: buffer payload is deliberately not reset; count alone decides which
  // slots hold live data, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (pop)  fifo_mem[0]      <= fifo_mem[1];
    if (push) fifo_mem[wr_idx] <= {mem_addr, mem_rdata};
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: PC and memory models, a scoreboard of
// expected fetches filled at issue and drained as the decoder consumes.
module tb_instr_fetch_unit;

  logic        clk, reset;
  logic [15:0] pc;
  logic        pc_advance, mem_req, mem_ack;
  logic [15:0] mem_addr;
  logic [13:0] mem_rdata;
  logic        flush, ir_valid, ir_ready;
  logic [13:0] ir;
  logic [15:0] ir_pc;

  logic        pc_load, mem_auto, man_ack;
  logic [15:0] pc_load_val;
  int          lat, wait_cnt;

  typedef struct packed {
    logic [15:0] addr;
    logic [13:0] instr;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] exp_next_addr, req_addr;
  logic        prev_req;
  int          tests, fails, issued, consumed, c0, i0, n;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_advance(pc_advance),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .flush(flush), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program counter: a branch load wins over an increment.
  always @(posedge clk or negedge reset) begin
    if (!reset)          pc <= 16'h0000;
    else if (pc_load)    pc <= pc_load_val;
    else if (pc_advance) pc <= pc + 16'd1;
  end

  // Memory acks in the lat-th cycle of a request, returning 0x3000 + addr.
  always @(posedge clk or negedge reset) begin
    if (!reset)                wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end
  assign mem_ack   = mem_auto ? (mem_req && wait_cnt == lat - 1) : man_ack;
  assign mem_rdata = 14'(16'h3000 + mem_addr);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_pc_advance"}, 32'(pc_advance), 32'd0);
    check({tag, "_ir"},         32'(ir),         32'd0);
    check({tag, "_ir_pc"},      32'(ir_pc),      32'd0);
    check({tag, "_ir_valid"},   32'(ir_valid),   32'd0);
  endtask

  task automatic monitor();
    sb_t e;
    if (pc_advance) begin
      check("issue_addr", 32'(mem_addr), 32'(exp_next_addr));
      check("issue_edge", 32'(prev_req), 32'd0);
      req_addr = mem_addr;
      e.addr   = exp_next_addr;
      e.instr  = 14'(16'h3000 + exp_next_addr);
      sb.push_back(e);
      exp_next_addr++;
      issued++;
    end else if (mem_req) begin
      check("addr_stable", 32'(mem_addr), 32'(req_addr));
    end
    if (ir_valid && ir_ready && !flush) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_ir",    32'(ir),    32'(e.instr));
        check("sb_ir_pc", 32'(ir_pc), 32'(e.addr));
      end
      consumed++;
    end
    prev_req = mem_req;
  endtask

  // Outputs are monitored on the falling edge; directed steps resume at
  // rising edge + 2 and drive inputs there.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
  endtask

  // Asserts reset between edges, reconfigures the models and releases it.
  task automatic apply_reset(input int lat_cfg, input logic ready_cfg);
    #1 reset = 1'b0;
    flush = 1'b0; pc_load = 1'b0; mem_auto = 1'b1; man_ack = 1'b0;
    lat = lat_cfg; ir_ready = ready_cfg;
    sb.delete();
    exp_next_addr = 16'h0000;
    #1 check_reset_outputs("rst");
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_second_wait_cycle(input string tag);
    n = 0;
    while (!(mem_req && !pc_advance) && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 20), 32'd1);
  endtask

  initial begin
    tests = 0; fails = 0; issued = 0; consumed = 0;
    reset = 1'b0; ir_ready = 1'b1; flush = 1'b0; pc_load = 1'b0;
    pc_load_val = 16'h0000; mem_auto = 1'b1; man_ack = 1'b0; lat = 1;
    exp_next_addr = 16'h0000; req_addr = 16'h0000; prev_req = 1'b0;
    #3 check_reset_outputs("init");
    @(posedge clk); #2;

    // Zero-wait memory, decoder always ready: one fetch every 2 cycles.
    apply_reset(1, 1'b1);
    c0 = consumed;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_pc_advance", 32'(pc_advance), 32'(i % 2 == 0));
      if (i == 2) begin
        check("t1_ir",       32'(ir),       32'h3000);
        check("t1_ir_pc",    32'(ir_pc),    32'h0000);
        check("t1_ir_valid", 32'(ir_valid), 32'd1);
      end
    end
    tick();
    tick();
    check("t1_consumed", 32'(consumed - c0), 32'd3);

    // Decoder stalled: buffer fills with 2 words, requests stop.
    apply_reset(1, 1'b0);
    i0 = issued;
    c0 = consumed;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i >= 3) check("t2_ir_hold", 32'(ir), 32'h3000);
    end
    check("t2_mem_req",  32'(mem_req),        32'd0);
    check("t2_ir_valid", 32'(ir_valid),       32'd1);
    check("t2_ir_pc",    32'(ir_pc),          32'h0000);
    check("t2_sb_size",  32'(sb.size()),      32'd2);
    check("t2_issued",   32'(issued - i0),    32'd2);
    ir_ready = 1'b1;
    repeat (5) tick();
    check("t2_resume", 32'(consumed - c0), 32'd3);

    // Four-cycle memory: request held, a single pc_advance.
    apply_reset(4, 1'b1);
    tick();
    check("t3_req_e1",  32'(mem_req),    32'd1);
    check("t3_addr_e1", 32'(mem_addr),   32'h0000);
    check("t3_adv_e1",  32'(pc_advance), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("t3_req_hold",  32'(mem_req),    32'd1);
      check("t3_addr_hold", 32'(mem_addr),   32'h0000);
      check("t3_adv_low",   32'(pc_advance), 32'd0);
    end
    tick();
    check("t3_req_drop", 32'(mem_req), 32'd0);
    tick();
    check("t3_adv_e6",  32'(pc_advance), 32'd1);
    check("t3_addr_e6", 32'(mem_addr),   32'h0001);

    // Flush during WAIT with a branch to 0x0040; ack arrives 2 cycles later.
    wait_second_wait_cycle("t4_wait_found");
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0040;
    sb.delete();
    exp_next_addr = 16'h0040;
    tick();
    flush = 1'b0; pc_load = 1'b0;
    check("t4_valid_f0", 32'(ir_valid), 32'd0);
    check("t4_req_drop", 32'(mem_req),  32'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t4_valid_low", 32'(ir_valid), 32'd0);
      if (i == 2) check("t4_req_released", 32'(mem_req), 32'd0);
      if (i == 3) begin
        check("t4_new_adv",  32'(pc_advance), 32'd1);
        check("t4_new_addr", 32'(mem_addr),   32'h0040);
      end
    end
    tick();
    check("t4_valid_f8", 32'(ir_valid), 32'd1);
    check("t4_ir_f8",    32'(ir),       32'h3040);
    check("t4_ir_pc_f8", 32'(ir_pc),    32'h0040);
    tick();

    // Flush and a stray ack together on a full buffer with the decoder ready.
    apply_reset(1, 1'b0);
    repeat (6) tick();
    check("t5_full_req",  32'(mem_req),   32'd0);
    check("t5_full_ir",   32'(ir),        32'h3000);
    check("t5_full_size", 32'(sb.size()), 32'd2);
    mem_auto = 1'b0; man_ack = 1'b1; flush = 1'b1; ir_ready = 1'b1;
    sb.delete();
    exp_next_addr = 16'h0002;
    c0 = consumed;
    tick();
    check("t5_ir_valid", 32'(ir_valid),   32'd0);
    check("t5_ir",       32'(ir),         32'd0);
    check("t5_ir_pc",    32'(ir_pc),      32'd0);
    check("t5_req",      32'(mem_req),    32'd0);
    check("t5_adv",      32'(pc_advance), 32'd0);
    man_ack = 1'b0; flush = 1'b0; mem_auto = 1'b1;
    tick();
    check("t5_relaunch_adv",  32'(pc_advance), 32'd1);
    check("t5_relaunch_addr", 32'(mem_addr),   32'h0002);
    repeat (4) tick();
    check("t5_consumed", 32'(consumed - c0), 32'd1);

    // Asynchronous reset in the middle of a WAIT; later acks are ignored.
    apply_reset(4, 1'b1);
    wait_second_wait_cycle("t6_wait_found");
    #1 reset = 1'b0;
    #1 check_reset_outputs("t6_async");
    mem_auto = 1'b0; man_ack = 1'b1; flush = 1'b1; lat = 1;
    sb.delete();
    exp_next_addr = 16'h0000;
    tick();
    tick();
    check("t6_in_reset_req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t6_ack_ignored_req",   32'(mem_req),    32'd0);
      check("t6_ack_ignored_valid", 32'(ir_valid),   32'd0);
      check("t6_ack_ignored_adv",   32'(pc_advance), 32'd0);
    end
    man_ack = 1'b0; flush = 1'b0; mem_auto = 1'b1;
    tick();
    check("t6_restart_adv",  32'(pc_advance), 32'd1);
    check("t6_restart_addr", 32'(mem_addr),   32'h0000);
    tick();
    tick();
    check("t6_restart_valid", 32'(ir_valid), 32'd1);
    check("t6_restart_ir",    32'(ir),       32'h3000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
